fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port n_reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port bubble  input  1  stall from hazard detection; fd register holds.
REQ-006 SHALL have port redirect_valid  input  1  taken branch/jump; flush and reload PC.
REQ-007 SHALL have port redirect_pc  input  ADDR_W  redirect target.
REQ-008 SHALL have port imem_req  output  1  fetch request.
REQ-009 SHALL have port imem_addr  output  ADDR_W  fetch address, stable while imem_req=1 and no ack.
REQ-010 SHALL have port imem_ack  input  1  read data valid; meaningful only while imem_req=1.
REQ-011 SHALL have port imem_rdata  input  instruction_s  fetched instruction.
REQ-012 SHALL have port fd_s_o  output  fd_s  fetch/decode register (valid, pc, instruction_fd).

Function
REQ-013 SHALL keep internal PC (next address to request), wrapping modulo 2^ADDR_W, incremented by 1 per accepted instruction.
REQ-014 SHALL implement FSM: S_IDLE (one cycle after reset release), S_REQ (imem_req=1), S_FULL (skid occupied, imem_req=0).
REQ-015 SHALL transition S_IDLE->S_REQ unconditionally; S_REQ->S_FULL on ack with bubble=1 and fd valid; S_FULL->S_REQ when bubble=0 or redirect_valid=1.
REQ-016 SHALL latch imem_addr in a request-address register at request start; held until ack.
REQ-017 SHALL, on ack with bubble=0, load fd_s_o with valid=1, pc=request address, instruction_fd=imem_rdata, and advance PC.
REQ-018 SHALL, on ack with bubble=1 and fd valid, capture instruction and address into one-entry skid, advance PC, deassert imem_req.
REQ-019 SHALL, when bubble=0 and skid full, move skid into fd_s_o and empty skid the same cycle.
REQ-020 SHALL hold fd_s_o unchanged while bubble=1 and redirect_valid=0.
REQ-021 SHALL support ack in the same cycle imem_req rises (zero-wait memory), giving one instruction per cycle when unstalled.
REQ-022 SHALL give redirect_valid priority over bubble and ack: fd valid cleared, instruction_fd=NOP, skid emptied, PC=redirect_pc.
REQ-023 SHALL, if redirect occurs while a request is outstanding (imem_req=1, no ack), keep imem_req/imem_addr stable, set drop flag, discard the next ack, then request redirect_pc next cycle.
REQ-024 SHALL, if redirect coincides with ack, discard that data with no drop flag set.
REQ-025 SHALL clear drop flag on the discarded ack; a second redirect while drop pending only updates PC.
REQ-026 SHALL never present an instruction fetched before a redirect after that redirect.

Reset
REQ-027 SHALL on n_reset=0 asynchronously set: state=S_IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, skid empty, drop flag=0, fd valid=0, fd pc=0, instruction_fd=NOP.
REQ-028 SHALL, on reset mid-request, abandon the request; any ack during reset is ignored.

Structure
REQ-029 SHALL take fd_s, instruction_s and the NOP constant from the shared definitions package; FSM state enum also defined there.
REQ-030 SHALL instantiate one sub-module fetch_skid (one-entry buffer: load, drain, flush, full).

Verification
REQ-031 SHALL cover: reset release, ack every cycle, no stall -> imem_addr 0,1,2,3; fd_s_o.pc 0,1,2 one cycle after each ack.
REQ-032 SHALL cover: bubble=1 for 3 cycles while fd holds pc=5 and ack for pc=6 arrives -> skid holds 6, imem_req=0, fd stays 5; bubble drop -> fd=6 next cycle, request 7.
REQ-033 SHALL cover: redirect_valid=1, redirect_pc=0x40, request for 9 outstanding -> imem_addr stays 9 until ack, that ack discarded, next imem_addr=0x40, fd valid=0 meanwhile.
REQ-034 SHALL cover: redirect coinciding with ack and bubble=1 -> fd valid=0, skid empty, next imem_addr=redirect_pc.
REQ-035 SHALL cover: PC at 0x3FF (ADDR_W=10), ack -> next imem_addr=0x000.
REQ-036 SHALL cover: n_reset asserted while skid full and drop pending -> all outputs to REQ-027 values same cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: instruction word, fetch/decode register and FSM states.
package fetch_unit_pkg;

    localparam int PC_W = 32;

    typedef struct packed {
        logic [31:0] bits;
    } instruction_s;

    // addi x0, x0, 0
    localparam instruction_s NOP = instruction_s'(32'h0000_0013);

    typedef struct packed {
        logic         valid;
        logic [PC_W-1:0] pc;
        instruction_s instruction_fd;
    } fd_s;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction that arrived while decode was stalled.
module fetch_skid
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  instruction_s      instr_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] pc_o,
    output instruction_s      instr_o
);

    logic              full_q;
    logic [ADDR_W-1:0] pc_q;
    instruction_s      instr_q;

    // flush beats load beats drain
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP;
        end else if (flush_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (drain_i) begin
            full_q  <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, memory request handshake, stall skid and redirect flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              bubble,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  instruction_s      imem_rdata,
    output fd_s               fd_s_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              drop_q, drop_d;
    fd_s               fd_q, fd_d;

    logic              ack;
    logic              skid_load, skid_drain, skid_flush;
    logic              skid_full;
    logic [ADDR_W-1:0] skid_pc;
    instruction_s      skid_instr;

    assign ack = imem_ack && (state_q == S_REQ);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        fd_d       = fd_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;

        if (redirect_valid) begin
            fd_d.valid          = 1'b0;
            fd_d.instruction_fd = NOP;
            skid_flush          = 1'b1;
            pc_d                = redirect_pc;
            unique case (state_q)
                S_REQ: begin
                    // An in-flight request must complete; its data is discarded later.
                    if (ack) begin
                        req_addr_d = redirect_pc;
                        drop_d     = 1'b0;
                    end else begin
                        drop_d     = 1'b1;
                    end
                end
                default: begin
                    state_d    = S_REQ;
                    req_addr_d = redirect_pc;
                    drop_d     = 1'b0;
                end
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d    = S_REQ;
                    req_addr_d = pc_q;
                end
                S_REQ: begin
                    if (!bubble) begin
                        fd_d.valid          = 1'b0;
                        fd_d.instruction_fd = NOP;
                    end
                    if (ack) begin
                        if (drop_q) begin
                            drop_d     = 1'b0;
                            req_addr_d = pc_q;
                        end else if (!bubble || !fd_q.valid) begin
                            // An empty fd has nothing to hold, so it takes the data directly.
                            fd_d = '{valid: 1'b1, pc: PC_W'(req_addr_q),
                                     instruction_fd: imem_rdata};
                            pc_d       = pc_q + ADDR_W'(1);
                            req_addr_d = pc_q + ADDR_W'(1);
                        end else begin
                            skid_load = 1'b1;
                            pc_d      = pc_q + ADDR_W'(1);
                            state_d   = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!bubble && skid_full) begin
                        fd_d = '{valid: 1'b1, pc: PC_W'(skid_pc),
                                 instruction_fd: skid_instr};
                        skid_drain = 1'b1;
                        state_d    = S_REQ;
                        req_addr_d = pc_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            fd_q       <= '{valid: 1'b0, pc: '0, instruction_fd: NOP};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            fd_q       <= fd_d;
        end
    end

    fetch_skid #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .n_reset (n_reset),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (skid_flush),
        .pc_i    (req_addr_q),
        .instr_i (imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = req_addr_q;
    assign fd_s_o    = fd_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall skid, redirects, wrap and reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         bubble;
    logic         redirect_valid;
    logic [9:0]   redirect_pc;
    logic         imem_req;
    logic [9:0]   imem_addr;
    logic         imem_ack;
    instruction_s imem_rdata;
    fd_s          fd_s_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory image: each word encodes its own address.
    assign imem_rdata.bits = 32'hA500_0000 | {22'd0, imem_addr};

    fetch_unit #(.ADDR_W(10), .RESET_PC(10'd0)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bubble         (bubble),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .fd_s_o         (fd_s_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fd(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, fd_s_o.valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".pc"}, fd_s_o.pc, pc);
            chk({tag, ".instr"}, fd_s_o.instruction_fd.bits, 32'hA500_0000 | pc);
        end else begin
            chk({tag, ".instr"}, fd_s_o.instruction_fd.bits, 32'h0000_0013);
        end
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [9:0] a);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
        chk({tag, ".addr"}, {22'd0, imem_addr}, {22'd0, a});
    endtask

    task automatic chk_reset(input string tag);
        chk_req(tag, 1'b0, 10'd0);
        chk_fd(tag, 1'b0, 32'd0);
        chk({tag, ".pc"}, fd_s_o.pc, 32'd0);
    endtask

    initial begin
        n_reset        = 1'b0;
        bubble         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");

        // Zero-wait streaming
        n_reset  = 1'b1;
        imem_ack = 1'b1;
        tick();
        chk_req("idle_to_req", 1'b1, 10'd0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_req("stream", 1'b1, 10'(i));
            chk_fd("stream", 1'b1, 32'(i - 1));
        end

        // Stall with fd=5 while 6 arrives
        bubble = 1'b1;
        repeat (3) begin
            tick();
            chk("stall.req", {31'd0, imem_req}, 32'd0);
            chk_fd("stall", 1'b1, 32'd5);
        end
        bubble = 1'b0;
        tick();
        chk_fd("unstall", 1'b1, 32'd6);
        chk_req("unstall", 1'b1, 10'd7);
        tick();
        chk_fd("s7", 1'b1, 32'd7);
        tick();
        chk_fd("s8", 1'b1, 32'd8);
        chk_req("s8", 1'b1, 10'd9);

        // Redirect while request for 9 is outstanding, then a second redirect
        imem_ack = 1'b0;
        tick();
        chk_req("wait9", 1'b1, 10'd9);
        chk_fd("wait9", 1'b0, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h030;
        tick();
        chk_req("redir1", 1'b1, 10'd9);
        chk_fd("redir1", 1'b0, 32'd0);
        redirect_pc = 10'h040;
        tick();
        chk_req("redir2", 1'b1, 10'd9);
        chk_fd("redir2", 1'b0, 32'd0);
        redirect_valid = 1'b0;
        imem_ack       = 1'b1;
        tick();
        chk_req("dropped", 1'b1, 10'h040);
        chk_fd("dropped", 1'b0, 32'd0);
        tick();
        chk_fd("tgt40", 1'b1, 32'h40);
        chk_req("tgt40", 1'b1, 10'h041);

        // Redirect coinciding with ack and bubble
        bubble         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 10'h080;
        tick();
        chk_fd("redir_ack", 1'b0, 32'd0);
        chk_req("redir_ack", 1'b1, 10'h080);
        bubble         = 1'b0;
        redirect_valid = 1'b0;
        tick();
        chk_fd("tgt80", 1'b1, 32'h80);
        chk_req("tgt80", 1'b1, 10'h081);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 10'h3FF;
        tick();
        chk_req("to3ff", 1'b1, 10'h3FF);
        redirect_valid = 1'b0;
        tick();
        chk_fd("wrap", 1'b1, 32'h3FF);
        chk_req("wrap", 1'b1, 10'h000);
        tick();
        chk_fd("wrap0", 1'b1, 32'h0);

        // Reset with skid full
        bubble = 1'b1;
        tick();
        chk("skid.req", {31'd0, imem_req}, 32'd0);
        chk_fd("skid", 1'b1, 32'd0);
        n_reset = 1'b0;
        #1;
        chk_reset("rst_skid");
        tick();
        chk_reset("rst_hold");
        n_reset = 1'b1;
        bubble  = 1'b0;
        tick();
        chk_req("restart1", 1'b1, 10'd0);
        chk_fd("restart1", 1'b0, 32'd0);
        tick();
        chk_fd("restart1b", 1'b1, 32'd0);

        // Reset with drop pending
        imem_ack = 1'b0;
        tick();
        chk_req("wait1", 1'b1, 10'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h020;
        tick();
        chk_req("drop_pend", 1'b1, 10'd1);
        redirect_valid = 1'b0;
        n_reset        = 1'b0;
        #1;
        chk_reset("rst_drop");
        tick();
        n_reset  = 1'b1;
        imem_ack = 1'b1;
        tick();
        chk_req("restart2", 1'b1, 10'd0);
        tick();
        chk_fd("restart2b", 1'b1, 32'd0);
        chk_req("restart2b", 1'b1, 10'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
